// File: rtl/ant_swarm_update_pkg.sv
// Shared opcodes, widths, colours, state types and the per-axis bounce helper
// for the ant swarm controller.
package ant_swarm_update_pkg;

    localparam int INSTRUCTION_WIDTH = 32;
    localparam int RESULT_WIDTH      = 32;
    localparam int COLOUR_W          = 3;

    localparam logic [3:0] DP_OP_DRAW  = 4'd1;
    localparam logic [3:0] DP_OP_LOAD  = 4'd2;
    localparam logic [3:0] DP_OP_STORE = 4'd3;

    localparam logic [COLOUR_W-1:0] COLOUR_BLACK = 3'b000;
    localparam logic [COLOUR_W-1:0] COLOUR_ANT   = 3'b010;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD_X,
        S_LOAD_Y,
        S_ERASE,
        S_COMPUTE,
        S_STORE_X,
        S_STORE_Y,
        S_DRAW,
        S_NEXT
    } swarm_state_e;

    typedef enum logic [1:0] {
        DP_IDLE,
        DP_ISSUE,
        DP_HOLD,
        DP_WAIT
    } dp_phase_e;

    typedef struct packed {
        logic        neg;
        logic [15:0] pos;
    } axis_t;

    // One bounced step on a single axis; neg=1 means moving towards 0.
    function automatic axis_t bounce(input logic [15:0] pos, input logic neg,
                                     input logic [15:0] max_v, input logic [15:0] step);
        axis_t       r;
        logic [16:0] sum;
        sum   = {1'b0, pos} + {1'b0, step};
        r.pos = pos;
        r.neg = neg;
        if (pos > max_v) begin
            r.pos = max_v;
            r.neg = 1'b1;
        end else if (!neg) begin
            if (sum >= {1'b0, max_v}) begin
                r.pos = max_v;
                r.neg = 1'b1;
            end else begin
                r.pos = sum[15:0];
            end
        end else if (pos <= step) begin
            r.pos = '0;
            r.neg = 1'b0;
        end else begin
            r.pos = pos - step;
        end
        return r;
    endfunction

endpackage

// File: rtl/ant_swarm_update_dp_request.sv
// One datapath request: ISSUE -> HOLD -> WAIT, with instruction held until the
// next ISSUE and a done pulse in the WAIT cycle that sees finished_dp.
module ant_swarm_update_dp_request
    import ant_swarm_update_pkg::*;
(
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         go,
    input  logic [INSTRUCTION_WIDTH-1:0] instr_in,
    input  logic                         finished_dp,
    input  logic [RESULT_WIDTH-1:0]      result_dp,
    output logic                         ready,
    output logic                         done,
    output logic [RESULT_WIDTH-1:0]      result,
    output logic                         start_dp,
    output logic [INSTRUCTION_WIDTH-1:0] instruction_dp
);

    dp_phase_e                    phase_q, phase_d;
    logic [INSTRUCTION_WIDTH-1:0] instr_q, instr_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            phase_q <= DP_IDLE;
            instr_q <= '0;
        end else begin
            phase_q <= phase_d;
            instr_q <= instr_d;
        end
    end

    always_comb begin
        phase_d = phase_q;
        instr_d = instr_q;
        done    = 1'b0;
        case (phase_q)
            DP_IDLE: begin
                if (go) begin
                    phase_d = DP_ISSUE;
                    instr_d = instr_in;
                end
            end
            DP_ISSUE: phase_d = DP_HOLD;
            DP_HOLD:  phase_d = DP_WAIT;
            DP_WAIT: begin
                if (finished_dp) begin
                    done    = 1'b1;
                    phase_d = DP_IDLE;
                end
            end
            default: phase_d = DP_IDLE;
        endcase
    end

    assign ready          = (phase_q == DP_IDLE);
    assign start_dp       = (phase_q == DP_ISSUE) || (phase_q == DP_HOLD);
    assign instruction_dp = instr_q;
    assign result         = result_dp;

endmodule

// File: rtl/ant_swarm_update.sv
// Walks NUM_ANTS ants: load x/y, bounce, store x/y, plot, all via the shared
// datapath port. Define ANT_SWARM_ERASE_EN to blank each ant's old position first.
module ant_swarm_update
    import ant_swarm_update_pkg::*;
#(
    parameter int          NUM_ANTS   = 4,
    parameter int          X_W        = 8,
    parameter int          Y_W        = 7,
    parameter int          ADDR_W     = 16,
    parameter logic [15:0] X_BASE     = 16'd0,
    parameter logic [15:0] Y_BASE     = 16'd64,
    parameter int          SCREEN_W   = 160,
    parameter int          SCREEN_H   = 120,
    parameter int          BLOCK_W    = 4,
    parameter int          BLOCK_H    = 4,
    parameter int          STEP       = 1,
    parameter logic [2:0]  ANT_COLOUR = COLOUR_ANT,
    localparam int         IDX_W      = (NUM_ANTS > 1) ? $clog2(NUM_ANTS) : 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start,
    output logic                         finished,
    output logic [IDX_W-1:0]             ant_index,
    input  logic                         finished_dp,
    input  logic [RESULT_WIDTH-1:0]      result_dp,
    output logic                         start_dp,
    output logic [INSTRUCTION_WIDTH-1:0] instruction_dp
);

    localparam int X_MAX = SCREEN_W - BLOCK_W;
    localparam int Y_MAX = SCREEN_H - BLOCK_H;

    swarm_state_e                 state_q, state_d;
    logic [IDX_W-1:0]             ant_idx_q, ant_idx_d;
    logic [X_W-1:0]               x_q, x_d;
    logic [Y_W-1:0]               y_q, y_d;
    logic [NUM_ANTS-1:0][1:0]     dir_q, dir_d;

    logic                         dp_go, dp_ready, dp_done;
    logic [INSTRUCTION_WIDTH-1:0] dp_instr;
    logic [RESULT_WIDTH-1:0]      dp_result;
    logic [ADDR_W-1:0]            x_addr, y_addr;
    axis_t                        ax, ay;
    logic                         unused_bits;

    ant_swarm_update_dp_request u_dp_request (
        .clock          (clock),
        .reset          (reset),
        .go             (dp_go),
        .instr_in       (dp_instr),
        .finished_dp    (finished_dp),
        .result_dp      (result_dp),
        .ready          (dp_ready),
        .done           (dp_done),
        .result         (dp_result),
        .start_dp       (start_dp),
        .instruction_dp (instruction_dp)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            ant_idx_q <= '0;
            x_q       <= '0;
            y_q       <= '0;
            dir_q     <= '0;
        end else begin
            state_q   <= state_d;
            ant_idx_q <= ant_idx_d;
            x_q       <= x_d;
            y_q       <= y_d;
            dir_q     <= dir_d;
        end
    end

    assign x_addr = ADDR_W'(X_BASE) + ADDR_W'(ant_idx_q);
    assign y_addr = ADDR_W'(Y_BASE) + ADDR_W'(ant_idx_q);

    // Direction bit 0 is x, bit 1 is y; a set bit means moving towards 0.
    assign ax = bounce(16'(x_q), dir_q[ant_idx_q][0], 16'(X_MAX), 16'(STEP));
    assign ay = bounce(16'(y_q), dir_q[ant_idx_q][1], 16'(Y_MAX), 16'(STEP));

    always_comb begin
        state_d   = state_q;
        ant_idx_d = ant_idx_q;
        x_d       = x_q;
        y_d       = y_q;
        dir_d     = dir_q;
        dp_go     = 1'b0;
        dp_instr  = '0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_LOAD_X;
            end
            S_LOAD_X: begin
                dp_go    = dp_ready;
                dp_instr = {DP_OP_LOAD, 12'd0, 16'(x_addr)};
                if (dp_done) begin
                    x_d     = dp_result[X_W-1:0];
                    state_d = S_LOAD_Y;
                end
            end
            S_LOAD_Y: begin
                dp_go    = dp_ready;
                dp_instr = {DP_OP_LOAD, 12'd0, 16'(y_addr)};
                if (dp_done) begin
                    y_d = dp_result[Y_W-1:0];
`ifdef ANT_SWARM_ERASE_EN
                    state_d = S_ERASE;
`else
                    state_d = S_COMPUTE;
`endif
                end
            end
`ifdef ANT_SWARM_ERASE_EN
            S_ERASE: begin
                dp_go    = dp_ready;
                dp_instr = 32'({DP_OP_DRAW, 9'd0, 1'b1, COLOUR_BLACK, y_q, x_q});
                if (dp_done) state_d = S_COMPUTE;
            end
`endif
            S_COMPUTE: begin
                x_d                 = ax.pos[X_W-1:0];
                y_d                 = ay.pos[Y_W-1:0];
                dir_d[ant_idx_q][0] = ax.neg;
                dir_d[ant_idx_q][1] = ay.neg;
                state_d             = S_STORE_X;
            end
            S_STORE_X: begin
                dp_go    = dp_ready;
                dp_instr = {DP_OP_STORE, 12'(x_q), 16'(x_addr)};
                if (dp_done) state_d = S_STORE_Y;
            end
            S_STORE_Y: begin
                dp_go    = dp_ready;
                dp_instr = {DP_OP_STORE, 12'(y_q), 16'(y_addr)};
                if (dp_done) state_d = S_DRAW;
            end
            S_DRAW: begin
                dp_go    = dp_ready;
                dp_instr = 32'({DP_OP_DRAW, 9'd0, 1'b1, ANT_COLOUR, y_q, x_q});
                if (dp_done) state_d = S_NEXT;
            end
            S_NEXT: begin
                if (ant_idx_q == IDX_W'(NUM_ANTS - 1)) begin
                    ant_idx_d = '0;
                    state_d   = S_IDLE;
                end else begin
                    ant_idx_d = ant_idx_q + 1'b1;
                    state_d   = S_LOAD_X;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign finished  = (state_q == S_IDLE);
    assign ant_index = ant_idx_q;

    // Only the low result bits and low axis bits carry meaning.
    assign unused_bits = ^{dp_result, ax.pos, ay.pos};

endmodule
